// File: rtl/tic_tac_toe_auto_player_if.sv
// Handshake and board bus between the game controller (master) and the auto player (slave).
interface tic_tac_toe_auto_player_if;
  localparam int unsigned CELL_W = 2;
  localparam int unsigned POS_W  = 4;

  logic              req;
  logic [CELL_W-1:0] pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9;
  logic [CELL_W-1:0] win;
  logic [POS_W-1:0]  pos_play0;
  logic              move_valid;
  logic              no_move;
  logic              busy;

  modport master (
    output req, pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9, win,
    input  pos_play0, move_valid, no_move, busy
  );

  modport slave (
    input  req, pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9, win,
    output pos_play0, move_valid, no_move, busy
  );
endinterface

// File: rtl/tic_tac_toe_auto_player.sv
// Automatic tic-tac-toe opponent: snapshots the board on req, scans lines one per cycle
// for a winning move, then a blocking move, then falls back to a fixed preference order.
module tic_tac_toe_auto_player #(
  parameter logic [1:0] ME           = 2'b10,
  parameter logic [1:0] OPP          = 2'b01,
  parameter bit         CENTER_FIRST = 1'b1
) (
  input logic                        clk,
  input logic                        rst,
  tic_tac_toe_auto_player_if.slave   bus
);

  localparam int unsigned CELL_W  = 2;
  localparam int unsigned POS_W   = 4;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned N_CELLS = 9;
  localparam logic [CELL_W-1:0] EMPTY    = 2'b00;
  localparam logic [IDX_W-1:0]  LAST_IDX = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN_WIN,
    S_SCAN_BLK,
    S_PREF,
    S_OUT,
    S_NOMV
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   w_idx_nxt;
  logic [POS_W-1:0]   r_pos;
  logic [POS_W-1:0]   w_pos_nxt;
  logic [CELL_W-1:0]  r_board [1:N_CELLS];
  logic               r_over;
  logic               r_move_valid;
  logic               r_no_move;
  logic               r_busy;
  logic               w_accept;
  logic [POS_W-1:0]   w_pa, w_pb, w_pc;
  logic [CELL_W-1:0]  w_mark;
  logic [POS_W-1:0]   w_hit_pos;
  logic [POS_W-1:0]   w_pref_pos;

  // Returns the empty cell of a line holding exactly two marks m and one empty cell, else 0.
  function automatic logic [POS_W-1:0] line_hit(
    input logic [CELL_W-1:0] ca, input logic [CELL_W-1:0] cb, input logic [CELL_W-1:0] cc,
    input logic [CELL_W-1:0] m,
    input logic [POS_W-1:0]  pa, input logic [POS_W-1:0]  pb, input logic [POS_W-1:0]  pc
  );
    line_hit = '0;
    if (ca == m && cb == m && cc == EMPTY)      line_hit = pc;
    else if (ca == m && cc == m && cb == EMPTY) line_hit = pb;
    else if (cb == m && cc == m && ca == EMPTY) line_hit = pa;
  endfunction

  // k-th cell of the fallback preference order.
  function automatic logic [POS_W-1:0] pref_at(input int unsigned k);
    case (k)
      0:       pref_at = CENTER_FIRST ? 4'd5 : 4'd1;
      1:       pref_at = CENTER_FIRST ? 4'd1 : 4'd3;
      2:       pref_at = CENTER_FIRST ? 4'd3 : 4'd7;
      3:       pref_at = CENTER_FIRST ? 4'd7 : 4'd9;
      4:       pref_at = CENTER_FIRST ? 4'd9 : 4'd5;
      5:       pref_at = 4'd2;
      6:       pref_at = 4'd4;
      7:       pref_at = 4'd6;
      default: pref_at = 4'd8;
    endcase
  endfunction

  // Line table lookup for the line currently under scan.
  always_comb begin
    w_pa = 4'd1;
    w_pb = 4'd2;
    w_pc = 4'd3;
    case (r_idx)
      3'd0:    begin w_pa = 4'd1; w_pb = 4'd2; w_pc = 4'd3; end
      3'd1:    begin w_pa = 4'd4; w_pb = 4'd5; w_pc = 4'd6; end
      3'd2:    begin w_pa = 4'd7; w_pb = 4'd8; w_pc = 4'd9; end
      3'd3:    begin w_pa = 4'd1; w_pb = 4'd4; w_pc = 4'd7; end
      3'd4:    begin w_pa = 4'd2; w_pb = 4'd5; w_pc = 4'd8; end
      3'd5:    begin w_pa = 4'd3; w_pb = 4'd6; w_pc = 4'd9; end
      3'd6:    begin w_pa = 4'd1; w_pb = 4'd5; w_pc = 4'd9; end
      default: begin w_pa = 4'd3; w_pb = 4'd5; w_pc = 4'd7; end
    endcase
  end

  assign w_mark    = (r_state == S_SCAN_BLK) ? OPP : ME;
  assign w_hit_pos = line_hit(r_board[w_pa], r_board[w_pb], r_board[w_pc],
                              w_mark, w_pa, w_pb, w_pc);

  // Reverse walk so the earliest empty cell in preference order is the one kept.
  always_comb begin
    w_pref_pos = '0;
    for (int k = N_CELLS - 1; k >= 0; k--) begin
      if (r_board[pref_at(k)] == EMPTY) w_pref_pos = pref_at(k);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state, scan index and result selection.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_pos_nxt   = r_pos;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.req) begin
          w_accept    = 1'b1;
          w_idx_nxt   = '0;
          w_state_nxt = S_SCAN_WIN;
        end
      end
      S_SCAN_WIN: begin
        if (r_over) begin
          w_pos_nxt   = '0;
          w_state_nxt = S_NOMV;
        end else if (w_hit_pos != '0) begin
          w_pos_nxt   = w_hit_pos;
          w_state_nxt = S_OUT;
        end else if (r_idx == LAST_IDX) begin
          w_idx_nxt   = '0;
          w_state_nxt = S_SCAN_BLK;
        end else begin
          w_idx_nxt   = r_idx + IDX_W'(1);
        end
      end
      S_SCAN_BLK: begin
        if (w_hit_pos != '0) begin
          w_pos_nxt   = w_hit_pos;
          w_state_nxt = S_OUT;
        end else if (r_idx == LAST_IDX) begin
          w_idx_nxt   = '0;
          w_state_nxt = S_PREF;
        end else begin
          w_idx_nxt   = r_idx + IDX_W'(1);
        end
      end
      S_PREF: begin
        w_pos_nxt   = w_pref_pos;
        w_state_nxt = (w_pref_pos != '0) ? S_OUT : S_NOMV;
      end
      S_OUT:   w_state_nxt = S_IDLE;
      S_NOMV:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Snapshot, datapath and registered strobes (strobes track the state being entered).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx        <= '0;
      r_pos        <= '0;
      r_over       <= 1'b0;
      r_move_valid <= 1'b0;
      r_no_move    <= 1'b0;
      r_busy       <= 1'b0;
      for (int i = 1; i <= N_CELLS; i++) r_board[i] <= '0;
    end else begin
      r_idx        <= w_idx_nxt;
      r_pos        <= w_pos_nxt;
      r_move_valid <= (w_state_nxt == S_OUT);
      r_no_move    <= (w_state_nxt == S_NOMV);
      r_busy       <= (w_state_nxt != S_IDLE);
      if (w_accept) begin
        r_over     <= (bus.win != 2'b00);
        r_board[1] <= bus.pos1;
        r_board[2] <= bus.pos2;
        r_board[3] <= bus.pos3;
        r_board[4] <= bus.pos4;
        r_board[5] <= bus.pos5;
        r_board[6] <= bus.pos6;
        r_board[7] <= bus.pos7;
        r_board[8] <= bus.pos8;
        r_board[9] <= bus.pos9;
      end
    end
  end

  assign bus.pos_play0  = r_pos;
  assign bus.move_valid = r_move_valid;
  assign bus.no_move    = r_no_move;
  assign bus.busy       = r_busy;

endmodule
